// File: rtl/ppu_spr_pkg.sv
// Shared definitions for the PPU sprite output bank: attribute bit map,
// plane bit-reverse helper and slot-index width helper.
package ppu_spr_pkg;

    localparam int ATTR_PRIO = 5;
    localparam int ATTR_MIRX = 6;

    // Slot index width; a single-slot bank still needs one index bit.
    function automatic int spr_sw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Reverse the low w bits of v (w <= 64); used for mirror-X pattern loads.
    function automatic logic [63:0] bitrev(input logic [63:0] v, input int w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < w) r[i] = v[w-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/ppu_spr_slot.sv
// One sprite slot: X down-counter, attribute latch, show counter and the
// two bit-plane shift registers. Exposes the current (pre-shift) pixel.
module ppu_spr_slot
    import ppu_spr_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int XW    = 8,
    parameter int PAL_W = 2
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_line_start,
    input  logic               i_sel,
    input  logic [XW-1:0]      i_xcnt,
    input  logic               i_xcnt_we,
    input  logic [7:0]         i_attr,
    input  logic               i_attr_we,
    input  logic [2*PIX_W-1:0] i_patt,
    input  logic               i_patt_we,
    input  logic               i_run,
    output logic               o_active,
    output logic               o_hi,
    output logic               o_lo,
    output logic [PAL_W-1:0]   o_pal,
    output logic               o_prio
);

    localparam int CW = $clog2(PIX_W) + 1;

    logic [XW-1:0]    xcnt_q, xcnt_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PIX_W-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [PAL_W-1:0] pal_q, pal_d;
    logic             prio_q, prio_d, mirx_q, mirx_d;

    logic             xwe, awe, pwe, ld, step, mirx;
    logic [PIX_W-1:0] hi_in, lo_in, hi_rev, lo_rev;

    assign hi_in = i_patt[2*PIX_W-1 -: PIX_W];
    assign lo_in = i_patt[PIX_W-1:0];

    // Next-state: loads win over shift/decrement; line start clears planes
    // and show counter but a same-cycle pattern load still lands.
    always_comb begin
        xwe    = i_sel & i_xcnt_we;
        awe    = i_sel & i_attr_we;
        pwe    = i_sel & i_patt_we;
        ld     = xwe | awe | pwe;
        step   = i_run && (xcnt_q == '0) && !ld;
        mirx   = awe ? i_attr[ATTR_MIRX] : mirx_q;
        hi_rev = PIX_W'(bitrev(64'(hi_in), PIX_W));
        lo_rev = PIX_W'(bitrev(64'(lo_in), PIX_W));

        xcnt_d = xcnt_q;
        if (xwe)                                   xcnt_d = i_xcnt;
        else if (i_run && xcnt_q != '0 && !ld)     xcnt_d = xcnt_q - 1'b1;

        pal_d  = pal_q;
        prio_d = prio_q;
        mirx_d = mirx_q;
        if (awe) begin
            pal_d  = i_attr[PAL_W-1:0];
            prio_d = i_attr[ATTR_PRIO];
            mirx_d = i_attr[ATTR_MIRX];
        end

        cnt_d = cnt_q;
        if (step && cnt_q < CW'(PIX_W)) cnt_d = cnt_q + 1'b1;
        if (i_line_start)               cnt_d = '0;

        hi_d = hi_q;
        lo_d = lo_q;
        if (step) begin
            hi_d = hi_q << 1;
            lo_d = lo_q << 1;
        end
        if (i_line_start) begin
            hi_d = '0;
            lo_d = '0;
        end
        if (pwe) begin
            hi_d = mirx ? hi_rev : hi_in;
            lo_d = mirx ? lo_rev : lo_in;
        end
    end

    // Slot state registers.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            xcnt_q <= '0;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            pal_q  <= '0;
            prio_q <= 1'b0;
            mirx_q <= 1'b0;
        end else begin
            xcnt_q <= xcnt_d;
            cnt_q  <= cnt_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            pal_q  <= pal_d;
            prio_q <= prio_d;
            mirx_q <= mirx_d;
        end
    end

    assign o_active = (xcnt_q == '0) && (cnt_q < CW'(PIX_W));
    assign o_hi     = hi_q[PIX_W-1];
    assign o_lo     = lo_q[PIX_W-1];
    assign o_pal    = pal_q;
    assign o_prio   = prio_q;

endmodule

// File: rtl/ppu_spr_bank.sv
// Sprite output bank: NSLOT slots, lowest-index opaque slot wins, one
// registered sprite pixel per cycle plus a sprite-0 hit candidate flag.
module ppu_spr_bank
    import ppu_spr_pkg::*;
#(
    parameter  int NSLOT = 8,
    parameter  int PIX_W = 8,
    parameter  int XW    = 8,
    parameter  int PAL_W = 2,
    localparam int SW    = spr_sw(NSLOT)
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_line_start,
    input  logic [SW-1:0]      i_slot,
    input  logic [XW-1:0]      i_xcnt,
    input  logic               i_xcnt_we,
    input  logic [7:0]         i_attr,
    input  logic               i_attr_we,
    input  logic [2*PIX_W-1:0] i_patt,
    input  logic               i_patt_we,
    input  logic               i_spr0_en,
    input  logic               i_run,
    output logic               o_valid,
    output logic               o_opaque,
    output logic               o_priority,
    output logic [PAL_W+1:0]   o_pattern,
    output logic [SW-1:0]      o_slot,
    output logic               o_spr0
);

    logic [NSLOT-1:0]            act, hi, lo, prio;
    logic [NSLOT-1:0][PAL_W-1:0] pal;

    // Index compare against in-range slot numbers only, so loads aimed at
    // i_slot >= NSLOT select nothing.
    for (genvar k = 0; k < NSLOT; k++) begin : g_slot
        ppu_spr_slot #(
            .PIX_W (PIX_W),
            .XW    (XW),
            .PAL_W (PAL_W)
        ) u_slot (
            .i_clk        (i_clk),
            .i_rstn       (i_rstn),
            .i_line_start (i_line_start),
            .i_sel        (i_slot == SW'(k)),
            .i_xcnt       (i_xcnt),
            .i_xcnt_we    (i_xcnt_we),
            .i_attr       (i_attr),
            .i_attr_we    (i_attr_we),
            .i_patt       (i_patt),
            .i_patt_we    (i_patt_we),
            .i_run        (i_run),
            .o_active     (act[k]),
            .o_hi         (hi[k]),
            .o_lo         (lo[k]),
            .o_pal        (pal[k]),
            .o_prio       (prio[k])
        );
    end

    logic               valid_q, valid_d, opaque_q, opaque_d, prio_q, prio_d;
    logic               spr0_q, spr0_d, spr0_flag_q, spr0_flag_d;
    logic [PAL_W+1:0]   pattern_q, pattern_d;
    logic [SW-1:0]      slot_q, slot_d;
    logic               found;

    // Fixed-priority pick of the lowest-index opaque active slot; the
    // sprite-0 flag is captured alongside slot 0's attribute load.
    always_comb begin
        found     = 1'b0;
        pattern_d = '0;
        prio_d    = 1'b0;
        slot_d    = '0;
        for (int k = 0; k < NSLOT; k++) begin
            if (!found && act[k] && (hi[k] | lo[k])) begin
                found     = 1'b1;
                pattern_d = {pal[k], hi[k], lo[k]};
                prio_d    = prio[k];
                slot_d    = SW'(k);
            end
        end
        spr0_flag_d = (i_attr_we && i_slot == '0) ? i_spr0_en : spr0_flag_q;
        valid_d     = i_run;
        opaque_d    = found;
        spr0_d      = found && (slot_d == '0) && spr0_flag_q;
    end

    // Output register, one cycle behind the slot state.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            valid_q     <= 1'b0;
            opaque_q    <= 1'b0;
            prio_q      <= 1'b0;
            pattern_q   <= '0;
            slot_q      <= '0;
            spr0_q      <= 1'b0;
            spr0_flag_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            opaque_q    <= opaque_d;
            prio_q      <= prio_d;
            pattern_q   <= pattern_d;
            slot_q      <= slot_d;
            spr0_q      <= spr0_d;
            spr0_flag_q <= spr0_flag_d;
        end
    end

    assign o_valid    = valid_q;
    assign o_opaque   = opaque_q;
    assign o_priority = prio_q;
    assign o_pattern  = pattern_q;
    assign o_slot     = slot_q;
    assign o_spr0     = spr0_q;

endmodule

// File: tb/tb_ppu_spr_bank.sv
// Bench for ppu_spr_bank (NSLOT=6): pixel-list model per slot, per-cycle
// compare on the negedge, plus literal expectations from the test plan.
module tb_ppu_spr_bank;

    localparam int NS = 6;

    logic        i_clk, i_rstn, i_line_start, i_xcnt_we, i_attr_we, i_patt_we;
    logic        i_spr0_en, i_run;
    logic [2:0]  i_slot;
    logic [7:0]  i_xcnt, i_attr;
    logic [15:0] i_patt;
    logic        o_valid, o_opaque, o_priority, o_spr0;
    logic [3:0]  o_pattern;
    logic [2:0]  o_slot;

    ppu_spr_bank #(.NSLOT(NS), .PIX_W(8), .XW(8), .PAL_W(2)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_line_start(i_line_start),
        .i_slot(i_slot), .i_xcnt(i_xcnt), .i_xcnt_we(i_xcnt_we),
        .i_attr(i_attr), .i_attr_we(i_attr_we), .i_patt(i_patt),
        .i_patt_we(i_patt_we), .i_spr0_en(i_spr0_en), .i_run(i_run),
        .o_valid(o_valid), .o_opaque(o_opaque), .o_priority(o_priority),
        .o_pattern(o_pattern), .o_slot(o_slot), .o_spr0(o_spr0)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: each slot holds its row as a list of pixels (index 0 = first
    // shown) plus a read index, an X count and a shown-pixel count.
    int  m_x[NS], m_cnt[NS], m_sh[NS], m_pal[NS];
    bit  m_ph[NS][8], m_pl[NS][8];
    bit  m_prio[NS], m_mir[NS];
    bit  m_s0;
    logic       exp_valid = 0, exp_op = 0, exp_prio = 0, exp_s0 = 0;
    logic [3:0] exp_pat = 0;
    logic [2:0] exp_slot = 0;

    task automatic model_reset();
        for (int k = 0; k < NS; k++) begin
            m_x[k] = 0; m_cnt[k] = 0; m_sh[k] = 8; m_pal[k] = 0;
            m_prio[k] = 0; m_mir[k] = 0;
            for (int j = 0; j < 8; j++) begin m_ph[k][j] = 0; m_pl[k][j] = 0; end
        end
        m_s0 = 0;
        exp_valid = 0; exp_op = 0; exp_prio = 0; exp_s0 = 0; exp_pat = 0; exp_slot = 0;
    endtask

    // One clock: predict the registered outputs, advance the model, clock
    // the DUT, then drop all strobes.
    task automatic cyc();
        bit f, sel, ld, mir;
        int w, ph, pl, xpre;
        logic [3:0] npat;
        logic [2:0] nsl;
        logic npr, nv, ns0;
        f = 0; w = 0; npat = 0; nsl = 0; npr = 0;
        for (int k = 0; k < NS; k++) begin
            ph = 0; pl = 0;
            if (m_sh[k] < 8) begin ph = m_ph[k][m_sh[k]]; pl = m_pl[k][m_sh[k]]; end
            if (!f && m_x[k] == 0 && m_cnt[k] < 8 && (ph + pl) != 0) begin
                f = 1; w = k;
                npat = 4'(m_pal[k] * 4 + ph * 2 + pl);
                npr = m_prio[k]; nsl = 3'(k);
            end
        end
        nv = i_run;
        ns0 = f && (w == 0) && m_s0;
        if (i_attr_we && i_slot == 0) m_s0 = i_spr0_en;
        for (int k = 0; k < NS; k++) begin
            sel  = (int'(i_slot) == k);
            ld   = sel && (i_xcnt_we || i_attr_we || i_patt_we);
            xpre = m_x[k];
            mir  = (sel && i_attr_we) ? i_attr[6] : m_mir[k];
            if (sel && i_attr_we) begin
                m_pal[k] = int'(i_attr[1:0]); m_prio[k] = i_attr[5]; m_mir[k] = i_attr[6];
            end
            if (sel && i_xcnt_we) m_x[k] = int'(i_xcnt);
            else if (i_run && m_x[k] > 0 && !ld) m_x[k] = m_x[k] - 1;
            if (i_run && xpre == 0 && !ld) begin
                if (m_sh[k] < 8) m_sh[k]++;
                if (m_cnt[k] < 8) m_cnt[k]++;
            end
            if (i_line_start) begin
                m_cnt[k] = 0;
                for (int j = 0; j < 8; j++) begin m_ph[k][j] = 0; m_pl[k][j] = 0; end
            end
            if (sel && i_patt_we) begin
                for (int j = 0; j < 8; j++) begin
                    m_ph[k][j] = mir ? i_patt[8+j] : i_patt[15-j];
                    m_pl[k][j] = mir ? i_patt[j]   : i_patt[7-j];
                end
                m_sh[k] = 0;
            end
        end
        @(posedge i_clk);
        exp_valid = nv; exp_op = f; exp_pat = npat; exp_prio = npr;
        exp_slot = nsl; exp_s0 = ns0;
        #2;
        i_line_start = 0; i_xcnt_we = 0; i_attr_we = 0; i_patt_we = 0; i_run = 0;
    endtask

    // Per-cycle compare against the model.
    always @(negedge i_clk) begin
        chk("valid", {31'd0, o_valid}, {31'd0, exp_valid});
        if (exp_valid) begin
            chk("opaque",   {31'd0, o_opaque},   {31'd0, exp_op});
            chk("pattern",  {28'd0, o_pattern},  {28'd0, exp_pat});
            chk("priority", {31'd0, o_priority}, {31'd0, exp_prio});
            chk("slot",     {29'd0, o_slot},     {29'd0, exp_slot});
            chk("spr0",     {31'd0, o_spr0},     {31'd0, exp_s0});
        end
    end

    task automatic ld_x(input int s, input int x);
        i_slot = 3'(s); i_xcnt = 8'(x); i_xcnt_we = 1; cyc();
    endtask
    task automatic ld_a(input int s, input logic [7:0] a);
        i_slot = 3'(s); i_attr = a; i_attr_we = 1; cyc();
    endtask
    task automatic ld_p(input int s, input logic [15:0] p);
        i_slot = 3'(s); i_patt = p; i_patt_we = 1; cyc();
    endtask
    task automatic ld_all(input int s, input int x, input logic [7:0] a, input logic [15:0] p);
        i_slot = 3'(s); i_xcnt = 8'(x); i_attr = a; i_patt = p;
        i_xcnt_we = 1; i_attr_we = 1; i_patt_we = 1; cyc();
    endtask
    task automatic line();
        i_line_start = 1; cyc();
    endtask

    int cap_pat[16], cap_op[16], cap_slot[16], cap_s0[16], cap_v[16];
    task automatic runp(input int n);
        for (int i = 0; i < n; i++) begin
            i_run = 1; cyc();
            cap_pat[i] = int'(o_pattern); cap_op[i] = int'(o_opaque);
            cap_slot[i] = int'(o_slot); cap_s0[i] = int'(o_spr0); cap_v[i] = int'(o_valid);
        end
    endtask
    function automatic int sum_op(input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += cap_op[i];
        return s;
    endfunction
    function automatic int sum_s0(input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += cap_s0[i];
        return s;
    endfunction

    initial begin
        i_rstn = 0; i_line_start = 0; i_slot = 0; i_xcnt = 0; i_xcnt_we = 0;
        i_attr = 0; i_attr_we = 0; i_patt = 0; i_patt_we = 0; i_spr0_en = 0; i_run = 0;
        model_reset();
        repeat (2) @(posedge i_clk);
        #2;
        chk("rst_valid",   {31'd0, o_valid},  0);
        chk("rst_opaque",  {31'd0, o_opaque}, 0);
        chk("rst_pattern", {28'd0, o_pattern}, 0);
        chk("rst_slot",    {29'd0, o_slot},   0);
        i_rstn = 1;
        @(posedge i_clk); #2;

        // 1: delayed sprite, plain pattern
        ld_x(0, 3); ld_a(0, 8'h01); ld_p(0, 16'hF00F);
        runp(12);
        chk("t1_valid0", cap_v[0], 1);
        chk("t1_lead_transp", cap_op[0] + cap_op[1] + cap_op[2], 0);
        chk("t1_pix0", cap_pat[3], 6);
        chk("t1_pix3", cap_pat[6], 6);
        chk("t1_pix4", cap_pat[7], 5);
        chk("t1_pix7", cap_pat[10], 5);
        chk("t1_after_row", cap_op[11], 0);
        cyc();

        // 2: mirror, separate then same-cycle attr+pattern load
        line(); ld_a(0, 8'h40); ld_p(0, 16'h8001);
        runp(8);
        chk("t2_first", cap_pat[0], 1);
        chk("t2_last",  cap_pat[7], 2);
        line(); ld_a(0, 8'h00);
        i_slot = 0; i_attr = 8'h40; i_attr_we = 1; i_patt = 16'h8001; i_patt_we = 1; cyc();
        runp(8);
        chk("t2b_first", cap_pat[0], 1);
        chk("t2b_last",  cap_pat[7], 2);

        // 3: overlap priority
        line(); ld_all(2, 0, 8'h01, 16'hFF00); ld_all(5, 0, 8'h22, 16'h00FF);
        runp(8);
        chk("t3_slot0", cap_slot[0], 2);
        chk("t3_pat0",  cap_pat[0], 6);
        chk("t3_slot7", cap_slot[7], 2);
        line(); ld_p(2, 16'h0000); ld_p(5, 16'h00FF);
        runp(4);
        chk("t3b_slot", cap_slot[0], 5);
        chk("t3b_pat",  cap_pat[0], 9);

        // 4: sprite-0 flag
        line(); i_spr0_en = 1; ld_all(0, 4, 8'h00, 16'hC300); i_spr0_en = 0;
        runp(14);
        chk("t4_s0_r4",  cap_s0[3], 0);
        chk("t4_s0_r5",  cap_s0[4], 1);
        chk("t4_s0_r6",  cap_s0[5], 1);
        chk("t4_s0_r7",  cap_s0[6], 0);
        chk("t4_s0_r11", cap_s0[10], 1);
        chk("t4_s0_r12", cap_s0[11], 1);
        chk("t4_s0_r13", cap_s0[12], 0);
        line(); ld_all(0, 4, 8'h00, 16'hC300);
        runp(14);
        chk("t4b_no_s0", sum_s0(14), 0);
        chk("t4b_opaque", cap_op[4], 1);

        // 5: line start mid-row
        line(); ld_x(1, 0); ld_a(1, 8'h03); ld_all(0, 0, 8'h00, 16'hFF00);
        runp(3);
        chk("t5_shown", cap_pat[0], 2);
        line();
        runp(5);
        chk("t5_cleared", sum_op(5), 0);
        i_line_start = 1; i_slot = 1; i_patt = 16'h00FF; i_patt_we = 1; cyc();
        runp(8);
        chk("t5_slot1", cap_slot[0], 1);
        chk("t5_pat1",  cap_pat[0], 13);
        chk("t5_last",  cap_op[7], 1);

        // 6: async reset mid-run, out-of-range loads
        line(); ld_all(0, 0, 8'h01, 16'hFF00);
        runp(2);
        chk("t6_pre", cap_pat[1], 6);
        i_run = 1; cyc(); i_run = 1;
        i_rstn = 0; model_reset();
        #1;
        chk("t6_rst_valid",  {31'd0, o_valid},  0);
        chk("t6_rst_opaque", {31'd0, o_opaque}, 0);
        chk("t6_rst_pat",    {28'd0, o_pattern}, 0);
        i_run = 0;
        repeat (3) @(posedge i_clk);
        #2; i_rstn = 1;
        runp(10);
        chk("t6_no_pix", sum_op(10), 0);
        line(); ld_all(6, 0, 8'h01, 16'hFFFF); ld_all(7, 0, 8'h01, 16'hFFFF);
        runp(4);
        chk("t6_oob", sum_op(4), 0);
        ld_all(0, 0, 8'h01, 16'hFF00);
        runp(1);
        chk("t6_reload", cap_pat[0], 6);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
